// File: rtl/fifo_rd_pkg.sv
// fifo_reader shared types and constants.
// Imported by the skid buffer and the top level.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

  localparam int FIFO_RD_LAT = 1;
  localparam int BUF_DEPTH   = 2;
  localparam int DEF_DATA_W  = 32;

  // True when one more read fits after this cycle's pop.
  function automatic logic has_credit(
    input logic [1:0] occ,
    input logic       infl,
    input logic       pop
  );
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
    return sum < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry ordered buffer for fifo_reader.
// head_q is always the oldest word.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case (occ_q)
      2'd0: begin
        if (push_i) begin
          head_d = data_i;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        unique case ({push_i, pop_i})
          2'b10: begin
            tail_d = data_i;
            occ_d  = 2'd2;
          end
          2'b01: occ_d = 2'd0;
          2'b11: head_d = data_i;
          default: ;
        endcase
      end
      default: begin
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) tail_d = data_i;
          else        occ_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign data_o = head_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side controller: RD/EMPTY in, valid/ready out.
// Optional pop counter under FIFO_RD_CNT_EN.
module fifo_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EN,
  input  logic              EMPTY,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              RD,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count
);

  rd_state_e              state_q, state_d;
  logic [FIFO_RD_LAT-1:0] infl_q;
  logic [1:0]             occ;
  logic                   pop;
  logic                   rd;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (EN) state_d = ACTIVE;
      end
      ACTIVE: begin
        rd = EN & ~EMPTY & has_credit(occ, infl_q[0], pop);
        if (!EN) state_d = DRAIN;
      end
      DRAIN: begin
        if (EN) state_d = ACTIVE;
        else if (occ == 2'd0 && !infl_q[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= rd;
    end
  end

  // A returning word always lands; credit reserved its slot.
  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (infl_q[0]),
    .pop_i  (pop),
    .data_i (fifo_data),
    .data_o (m_data),
    .occ_o  (occ)
  );

  assign RD = rd;

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = pop ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO.
// Counter checks follow FIFO_RD_CNT_EN.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        EN;
  logic        EMPTY;
  logic [31:0] fifo_data = '0;
  logic        RD;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        busy;
  logic [3:0]  rd_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];
  int wptr = 0;
  int rptr = 0;

  always #5 clk = ~clk;

  assign EMPTY = (rptr == wptr);

  always @(posedge clk) begin
    if (RD) begin
      fifo_data <= mem[rptr];
      rptr      <= rptr + 1;
    end
  end

  fifo_reader #(
    .DATA_W (32),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .EN        (EN),
    .EMPTY     (EMPTY),
    .fifo_data (fifo_data),
    .RD        (RD),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .busy      (busy),
    .rd_count  (rd_count)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wptr] = 32'(base + i);
      wptr = wptr + 1;
    end
  endtask

  function automatic logic [63:0] cnt_exp(input int n);
`ifdef FIFO_RD_CNT_EN
    return 64'(n % 16);
`else
    return 64'(n * 0);
`endif
  endfunction

  initial begin
    reset   = 1'b0;
    EN      = 1'b0;
    m_ready = 1'b0;
    #2;
    chk("rst_rd",     64'(RD),       64'd0);
    chk("rst_valid",  64'(m_valid),  64'd0);
    chk("rst_data",   64'(m_data),   64'd0);
    chk("rst_busy",   64'(busy),     64'd0);
    chk("rst_cnt",    64'(rd_count), 64'd0);
    tick();
    tick();
    reset = 1'b1;

    // EN with an empty FIFO
    EN = 1'b1;
    #1;
    chk("emp_rd0", 64'(RD), 64'd0);
    tick();
    chk("emp_busy", 64'(busy),    64'd1);
    chk("emp_rd1",  64'(RD),      64'd0);
    chk("emp_v1",   64'(m_valid), 64'd0);
    tick();
    chk("emp_rd2",  64'(RD),      64'd0);
    chk("emp_v2",   64'(m_valid), 64'd0);
    EN = 1'b0;
    tick();
    chk("emp_drain", 64'(busy), 64'd1);
    tick();
    chk("emp_idle",  64'(busy), 64'd0);

    // Streaming 1..4 with m_ready held
    push_words(1, 4);
    m_ready = 1'b1;
    EN      = 1'b1;
    #1;
    chk("st_rd0", 64'(RD), 64'd0);
    tick();
    chk("st_rd1", 64'(RD),      64'd1);
    chk("st_v1",  64'(m_valid), 64'd0);
    tick();
    chk("st_rd2", 64'(RD),      64'd1);
    chk("st_v2",  64'(m_valid), 64'd0);
    tick();
    chk("st_rd3", 64'(RD),      64'd1);
    chk("st_v3",  64'(m_valid), 64'd1);
    chk("st_d1",  64'(m_data),  64'h1);
    tick();
    chk("st_rd4", 64'(RD),      64'd1);
    chk("st_d2",  64'(m_data),  64'h2);
    tick();
    chk("st_rd5", 64'(RD),      64'd0);
    chk("st_v5",  64'(m_valid), 64'd1);
    chk("st_d3",  64'(m_data),  64'h3);
    tick();
    chk("st_v6",  64'(m_valid), 64'd1);
    chk("st_d4",  64'(m_data),  64'h4);
    tick();
    chk("st_v7",  64'(m_valid), 64'd0);
    chk("st_cnt", 64'(rd_count), cnt_exp(4));

    // Backpressure with 5..8
    m_ready = 1'b0;
    push_words(5, 4);
    #1;
    chk("bp_rd0", 64'(RD), 64'd1);
    tick();
    chk("bp_rd1", 64'(RD),      64'd1);
    chk("bp_v1",  64'(m_valid), 64'd0);
    tick();
    chk("bp_rd2", 64'(RD),      64'd0);
    chk("bp_v2",  64'(m_valid), 64'd1);
    chk("bp_d2",  64'(m_data),  64'h5);
    tick();
    chk("bp_rd3", 64'(RD),      64'd0);
    chk("bp_d3",  64'(m_data),  64'h5);
    tick();
    chk("bp_rd4", 64'(RD),      64'd0);
    chk("bp_v4",  64'(m_valid), 64'd1);
    chk("bp_d4",  64'(m_data),  64'h5);
    m_ready = 1'b1;
    #1;
    chk("bp_rdr", 64'(RD), 64'd1);
    tick();
    chk("bp_d6",  64'(m_data), 64'h6);
    chk("bp_rd6", 64'(RD),     64'd1);
    tick();
    chk("bp_d7",  64'(m_data), 64'h7);
    chk("bp_rd7", 64'(RD),     64'd0);
    tick();
    chk("bp_v8",  64'(m_valid), 64'd1);
    chk("bp_d8",  64'(m_data),  64'h8);
    tick();
    chk("bp_vend", 64'(m_valid),  64'd0);
    chk("bp_cnt",  64'(rd_count), cnt_exp(8));

    // EN dropped after one RD
    push_words(9, 3);
    #1;
    chk("dr_rd0", 64'(RD), 64'd1);
    tick();
    EN = 1'b0;
    #1;
    chk("dr_rd1", 64'(RD), 64'd0);
    tick();
    chk("dr_v2",    64'(m_valid), 64'd1);
    chk("dr_d9",    64'(m_data),  64'h9);
    chk("dr_busy2", 64'(busy),    64'd1);
    chk("dr_rd2",   64'(RD),      64'd0);
    tick();
    chk("dr_v3",    64'(m_valid), 64'd0);
    chk("dr_busy3", 64'(busy),    64'd1);
    tick();
    chk("dr_busy4", 64'(busy),     64'd0);
    chk("dr_rd4",   64'(RD),       64'd0);
    chk("dr_cnt",   64'(rd_count), cnt_exp(9));

    // Reset with two words buffered
    m_ready = 1'b0;
    push_words(12, 1);
    EN = 1'b1;
    #1;
    chk("rs_rd0", 64'(RD), 64'd0);
    tick();
    chk("rs_rd1", 64'(RD), 64'd1);
    tick();
    chk("rs_rd2", 64'(RD), 64'd1);
    tick();
    chk("rs_rd3", 64'(RD),     64'd0);
    chk("rs_d3",  64'(m_data), 64'ha);
    tick();
    chk("rs_v4",  64'(m_valid), 64'd1);
    chk("rs_d4",  64'(m_data),  64'ha);
    #3;
    reset = 1'b0;
    #1;
    chk("rs_av",    64'(m_valid),  64'd0);
    chk("rs_ard",   64'(RD),       64'd0);
    chk("rs_adata", 64'(m_data),   64'd0);
    chk("rs_abusy", 64'(busy),     64'd0);
    chk("rs_acnt",  64'(rd_count), 64'd0);
    tick();
    reset   = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("rs_rdj1", 64'(RD),      64'd1);
    tick();
    chk("rs_vj2",  64'(m_valid), 64'd0);
    chk("rs_rdj2", 64'(RD),      64'd0);
    tick();
    chk("rs_vj3",  64'(m_valid), 64'd1);
    chk("rs_dj3",  64'(m_data),  64'hc);
    tick();
    chk("rs_vj4",  64'(m_valid),  64'd0);
    chk("rs_cnt",  64'(rd_count), cnt_exp(1));
    EN = 1'b0;
    tick();
    tick();
    chk("rs_idle", 64'(busy), 64'd0);

    // Sixteen more words: counter wraps to 1
    push_words(32'h100, 16);
    EN = 1'b1;
    repeat (3) tick();
    chk("wr_v3",  64'(m_valid), 64'd1);
    chk("wr_d3",  64'(m_data),  64'h100);
    repeat (15) tick();
    chk("wr_v18", 64'(m_valid), 64'd1);
    chk("wr_d18", 64'(m_data),  64'h10f);
    tick();
    chk("wr_v19", 64'(m_valid),  64'd0);
    chk("wr_cnt", 64'(rd_count), cnt_exp(17));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
